// File: rtl/matrix_writeback_seq_pkg.sv
// Shared matrix-unit definitions: writeback FSM state type and default geometry.
package matrix_writeback_seq_pkg;

  localparam int unsigned MAT_ELEM_W    = 8;
  localparam int unsigned MAT_NUM_ELEMS = 4;
  localparam int unsigned MAT_REG_AW    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/matrix_writeback_seq.sv
// Serialises one captured result vector into consecutive register-file writes,
// one element per accepted write, with flush abort and start-drop reporting.
module matrix_writeback_seq
  import matrix_writeback_seq_pkg::*;
#(
  parameter int unsigned ELEM_W    = MAT_ELEM_W,
  parameter int unsigned NUM_ELEMS = MAT_NUM_ELEMS,
  parameter int unsigned REG_AW    = MAT_REG_AW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [REG_AW-1:0]           base_reg,
  input  logic [NUM_ELEMS*ELEM_W-1:0] result,
  input  logic                        flush,
  input  logic                        wr_ready,
  output logic                        wr_en,
  output logic [REG_AW-1:0]           wr_addr,
  output logic [ELEM_W-1:0]           wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        start_drop
);

  localparam int unsigned IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  wb_state_e                   state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_ELEMS*ELEM_W-1:0] cap_result_q, cap_result_d;
  logic [REG_AW-1:0]           cap_base_q, cap_base_d;
  logic                        wr_en_q, wr_en_d;
  logic [REG_AW-1:0]           wr_addr_q, wr_addr_d;
  logic [ELEM_W-1:0]           wr_data_q, wr_data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        start_drop_q, start_drop_d;

  logic                        accept;
  logic [NUM_ELEMS*ELEM_W-1:0] src_result;
  logic [REG_AW-1:0]           src_base;

  always_comb begin
    accept       = start && !flush && (state_q != ST_WRITE);
    state_d      = state_q;
    idx_d        = idx_q;
    cap_result_d = cap_result_q;
    cap_base_d   = cap_base_q;
    start_drop_d = 1'b0;

    unique case (state_q)
      ST_WRITE: begin
        start_drop_d = start && !flush;
        if (wr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d      = ST_WRITE;
          idx_d        = '0;
          cap_result_d = result;
          cap_base_d   = base_reg;
        end
      end
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end

    // Outputs are registered, so on acceptance the first element must come
    // straight from the inputs rather than the not-yet-loaded capture regs.
    src_result = accept ? result : cap_result_q;
    src_base   = accept ? base_reg : cap_base_q;

    busy_d    = (state_d == ST_WRITE);
    wr_en_d   = busy_d;
    done_d    = (state_d == ST_DONE);
    wr_data_d = busy_d ? src_result[idx_d*ELEM_W +: ELEM_W] : '0;
    wr_addr_d = busy_d ? (src_base + REG_AW'(idx_d)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cap_result_q <= '0;
      cap_base_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cap_result_q <= cap_result_d;
      cap_base_q   <= cap_base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_drop_q <= start_drop_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign start_drop = start_drop_q;

endmodule

// File: tb/tb_matrix_writeback_seq.sv
// Directed bench for matrix_writeback_seq: default geometry, a wide 8-element
// configuration and the single-element case.
module tb_matrix_writeback_seq;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic wr_ready;

  logic        start_a;
  logic [2:0]  base_a;
  logic [31:0] result_a;
  logic        wr_en_a, busy_a, done_a, start_drop_a;
  logic [2:0]  wr_addr_a;
  logic [7:0]  wr_data_a;

  logic         start_b;
  logic [3:0]   base_b;
  logic [127:0] result_b;
  logic         wr_en_b, busy_b, done_b, start_drop_b;
  logic [3:0]   wr_addr_b;
  logic [15:0]  wr_data_b;

  logic        start_c;
  logic [2:0]  base_c;
  logic [7:0]  result_c;
  logic        wr_en_c, busy_c, done_c, start_drop_c;
  logic [2:0]  wr_addr_c;
  logic [7:0]  wr_data_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_writeback_seq dut_a (
    .clk(clk), .reset(reset), .start(start_a), .base_reg(base_a), .result(result_a),
    .flush(flush), .wr_ready(wr_ready), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .busy(busy_a), .done(done_a), .start_drop(start_drop_a)
  );

  matrix_writeback_seq #(.ELEM_W(16), .NUM_ELEMS(8), .REG_AW(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base_reg(base_b), .result(result_b),
    .flush(flush), .wr_ready(wr_ready), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .start_drop(start_drop_b)
  );

  matrix_writeback_seq #(.ELEM_W(8), .NUM_ELEMS(1), .REG_AW(3)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .base_reg(base_c), .result(result_c),
    .flush(flush), .wr_ready(wr_ready), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
    .wr_data(wr_data_c), .busy(busy_c), .done(done_c), .start_drop(start_drop_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed order: {wr_en, wr_addr, wr_data, busy, done, start_drop}
  task automatic chk_a(input string tag, input logic en, input logic [2:0] ad,
                       input logic [7:0] d, input logic bs, input logic dn, input logic dr);
    check(tag, {17'd0, wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a, start_drop_a},
               {17'd0, en, ad, d, bs, dn, dr});
  endtask

  task automatic chk_b(input string tag, input logic en, input logic [3:0] ad,
                       input logic [15:0] d, input logic bs, input logic dn, input logic dr);
    check(tag, {8'd0, wr_en_b, wr_addr_b, wr_data_b, busy_b, done_b, start_drop_b},
               {8'd0, en, ad, d, bs, dn, dr});
  endtask

  task automatic chk_c(input string tag, input logic en, input logic [2:0] ad,
                       input logic [7:0] d, input logic bs, input logic dn, input logic dr);
    check(tag, {17'd0, wr_en_c, wr_addr_c, wr_data_c, busy_c, done_c, start_drop_c},
               {17'd0, en, ad, d, bs, dn, dr});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr_ready = 1'b1;
    start_a = 1'b0; base_a = '0; result_a = '0;
    start_b = 1'b0; base_b = '0; result_b = '0;
    start_c = 1'b0; base_c = '0; result_c = '0;

    tick(); tick();
    chk_a("rst_a", 0, 3'd0, 8'h00, 0, 0, 0);
    chk_b("rst_b", 0, 4'd0, 16'h0000, 0, 0, 0);
    chk_c("rst_c", 0, 3'd0, 8'h00, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_a("idle_a", 0, 3'd0, 8'h00, 0, 0, 0);

    // Basic sequence, base 0
    start_a = 1'b1; base_a = 3'd0; result_a = 32'hDDCCBBAA;
    tick(); chk_a("basic_c1", 1, 3'd0, 8'hAA, 1, 0, 0);
    start_a = 1'b0; result_a = 32'h12345678; base_a = 3'd3;
    tick(); chk_a("basic_c2", 1, 3'd1, 8'hBB, 1, 0, 0);
    tick(); chk_a("basic_c3", 1, 3'd2, 8'hCC, 1, 0, 0);
    tick(); chk_a("basic_c4", 1, 3'd3, 8'hDD, 1, 0, 0);
    tick(); chk_a("basic_done", 0, 3'd0, 8'h00, 0, 1, 0);
    tick(); chk_a("basic_idle", 0, 3'd0, 8'h00, 0, 0, 0);

    // Address wrap from base 6
    start_a = 1'b1; base_a = 3'd6; result_a = 32'hDDCCBBAA;
    tick(); chk_a("wrap_c1", 1, 3'd6, 8'hAA, 1, 0, 0);
    start_a = 1'b0;
    tick(); chk_a("wrap_c2", 1, 3'd7, 8'hBB, 1, 0, 0);
    tick(); chk_a("wrap_c3", 1, 3'd0, 8'hCC, 1, 0, 0);
    tick(); chk_a("wrap_c4", 1, 3'd1, 8'hDD, 1, 0, 0);
    tick(); chk_a("wrap_done", 0, 3'd0, 8'h00, 0, 1, 0);
    tick(); chk_a("wrap_idle", 0, 3'd0, 8'h00, 0, 0, 0);

    // Back-pressure: wr_ready low in cycles 2-3
    start_a = 1'b1; base_a = 3'd0; result_a = 32'hDDCCBBAA;
    tick(); chk_a("bp_c1", 1, 3'd0, 8'hAA, 1, 0, 0);
    start_a = 1'b0;
    tick(); chk_a("bp_c2", 1, 3'd1, 8'hBB, 1, 0, 0);
    wr_ready = 1'b0;
    tick(); chk_a("bp_c3", 1, 3'd1, 8'hBB, 1, 0, 0);
    tick(); chk_a("bp_c4", 1, 3'd1, 8'hBB, 1, 0, 0);
    wr_ready = 1'b1;
    tick(); chk_a("bp_c5", 1, 3'd2, 8'hCC, 1, 0, 0);
    tick(); chk_a("bp_c6", 1, 3'd3, 8'hDD, 1, 0, 0);
    tick(); chk_a("bp_done", 0, 3'd0, 8'h00, 0, 1, 0);
    tick(); chk_a("bp_idle", 0, 3'd0, 8'h00, 0, 0, 0);

    // Start during WRITE is dropped; start in DONE chains without a gap
    start_a = 1'b1; base_a = 3'd0; result_a = 32'hDDCCBBAA;
    tick(); chk_a("drop_c1", 1, 3'd0, 8'hAA, 1, 0, 0);
    start_a = 1'b0;
    tick(); chk_a("drop_c2", 1, 3'd1, 8'hBB, 1, 0, 0);
    start_a = 1'b1; base_a = 3'd5; result_a = 32'h99887766;
    tick(); chk_a("drop_c3", 1, 3'd2, 8'hCC, 1, 0, 1);
    start_a = 1'b0;
    tick(); chk_a("drop_c4", 1, 3'd3, 8'hDD, 1, 0, 0);
    tick(); chk_a("drop_done", 0, 3'd0, 8'h00, 0, 1, 0);
    start_a = 1'b1; base_a = 3'd4; result_a = 32'h44332211;
    tick(); chk_a("chain_c6", 1, 3'd4, 8'h11, 1, 0, 0);
    start_a = 1'b0;
    tick(); chk_a("chain_c7", 1, 3'd5, 8'h22, 1, 0, 0);
    tick(); chk_a("chain_c8", 1, 3'd6, 8'h33, 1, 0, 0);
    tick(); chk_a("chain_c9", 1, 3'd7, 8'h44, 1, 0, 0);
    tick(); chk_a("chain_done", 0, 3'd0, 8'h00, 0, 1, 0);
    tick(); chk_a("chain_idle", 0, 3'd0, 8'h00, 0, 0, 0);

    // Flush after element 1 completes, with a simultaneous start
    start_a = 1'b1; base_a = 3'd0; result_a = 32'hDDCCBBAA;
    tick(); chk_a("fl_c1", 1, 3'd0, 8'hAA, 1, 0, 0);
    start_a = 1'b0;
    tick(); chk_a("fl_c2", 1, 3'd1, 8'hBB, 1, 0, 0);
    tick(); chk_a("fl_c3", 1, 3'd2, 8'hCC, 1, 0, 0);
    flush = 1'b1; start_a = 1'b1;
    tick(); chk_a("fl_c4", 0, 3'd0, 8'h00, 0, 0, 0);
    flush = 1'b0; start_a = 1'b0;
    tick(); chk_a("fl_c5", 0, 3'd0, 8'h00, 0, 0, 0);

    // Asynchronous reset mid-sequence
    start_a = 1'b1; base_a = 3'd2; result_a = 32'hDDCCBBAA;
    tick(); chk_a("ar_c1", 1, 3'd2, 8'hAA, 1, 0, 0);
    start_a = 1'b0;
    tick(); chk_a("ar_c2", 1, 3'd3, 8'hBB, 1, 0, 0);
    #2 reset = 1'b1;
    #1 chk_a("ar_async", 0, 3'd0, 8'h00, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick(); chk_a("ar_post1", 0, 3'd0, 8'h00, 0, 0, 0);
    tick(); chk_a("ar_post2", 0, 3'd0, 8'h00, 0, 0, 0);
    tick(); chk_a("ar_post3", 0, 3'd0, 8'h00, 0, 0, 0);

    // Wide configuration: 8 x 16-bit elements, 4-bit address wrapping from 13
    for (int unsigned k = 0; k < 8; k++) result_b[k*16 +: 16] = 16'hA0B0 + 16'(k);
    start_b = 1'b1; base_b = 4'd13;
    for (int unsigned k = 0; k < 8; k++) begin
      tick();
      start_b = 1'b0; result_b = '1; base_b = 4'd0;
      chk_b($sformatf("wide_e%0d", k), 1, 4'((13 + k) % 16), 16'hA0B0 + 16'(k), 1, 0, 0);
    end
    tick(); chk_b("wide_done", 0, 4'd0, 16'h0000, 0, 1, 0);
    tick(); chk_b("wide_idle", 0, 4'd0, 16'h0000, 0, 0, 0);

    // Single-element configuration
    start_c = 1'b1; base_c = 3'd7; result_c = 8'h5A;
    tick(); chk_c("one_wr", 1, 3'd7, 8'h5A, 1, 0, 0);
    start_c = 1'b0; result_c = 8'hFF;
    tick(); chk_c("one_done", 0, 3'd0, 8'h00, 0, 1, 0);
    tick(); chk_c("one_idle", 0, 3'd0, 8'h00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
